// File: rtl/riscv_mc_controller_pkg.sv
// Shared types and encodings for the multicycle RISC-V controller.
// States, opcodes and datapath select encodings used by the FSM and the ALU decoder.
package riscv_mc_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_HALT
  } state_e;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Selector between the FSM and the ALU decoder.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  function automatic logic [1:0] imm_src(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/riscv_alu_decoder.sv
// ALU operation decoder: fixed add/sub for the FSM, or funct3/funct7 decode for ALU instructions.
module riscv_alu_decoder
  import riscv_mc_controller_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] ALUControl
);

  always_comb begin
    ALUControl = ALU_ADD;
    case (aluop)
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op5 separates R-type from I-type, so addi never turns into sub.
          3'b000:  ALUControl = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_mc_controller.sv
// Multicycle RISC-V control FSM (lw, sw, R-type, I-ALU, beq, jal; illegal opcodes halt).
// Optional MCCTRL_MEMREADY_EN: FETCH, MEMREAD and MEMWRITE wait for mem_ready.
module riscv_mc_controller
  import riscv_mc_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       instr_done,
  output logic       halted
);

  state_e     state_q, state_d;
  logic       instr_done_q, instr_done_d;
  logic       mem_go;
  logic       pc_write, mem_write, ir_write, reg_write;
  logic [1:0] aluop;

`ifdef MCCTRL_MEMREADY_EN
  assign mem_go = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_go           = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_FETCH;
      instr_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_done_q <= instr_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_go) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTER;
          OP_IALU:      state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_HALT;
        endcase
      end
      // Only lw and sw reach MEMADR; bit 5 tells them apart.
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_go) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_go) state_d = S_FETCH;
      S_MEMWB, S_ALUWB, S_BEQ:          state_d = S_FETCH;
      S_EXECUTER, S_EXECUTEI, S_JAL:    state_d = S_ALUWB;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    instr_done_d = 1'b0;
    if (state_d == S_FETCH &&
        (state_q == S_MEMWB || state_q == S_MEMWRITE ||
         state_q == S_ALUWB || state_q == S_BEQ))
      instr_done_d = 1'b1;
  end

  always_comb begin
    pc_write  = 1'b0;
    AdrSrc    = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    aluop     = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ir_write  = mem_go;
        pc_write  = mem_go;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = mem_go;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_write = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_RD2;
        aluop   = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB:   reg_write = 1'b1;
      S_BEQ: begin
        ALUSrcA  = SRCA_RD1;
        ALUSrcB  = SRCB_RD2;
        aluop    = ALUOP_SUB;
        pc_write = Zero;
      end
      S_JAL: begin
        ALUSrcA  = SRCA_OLDPC;
        ALUSrcB  = SRCB_FOUR;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  riscv_alu_decoder u_alu_dec (
    .aluop     (aluop),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .op5       (op[5]),
    .ALUControl(ALUControl)
  );

  // Enables are gated by reset so nothing is written while it is held low.
  assign PCWrite    = pc_write  & reset;
  assign IRWrite    = ir_write  & reset;
  assign MemWrite   = mem_write & reset;
  assign RegWrite   = reg_write & reset;
  assign ImmSrc     = imm_src(op);
  assign instr_done = instr_done_q;
  assign halted     = (state_q == S_HALT);

endmodule
